// File: rtl/pcss_chip_pkg.sv
// Shared types and width helpers for the off-chip link (tx and future rx side).
package pcss_chip_pkg;

    // Ceiling log2, never less than 1 so it can always size a vector.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int calc_dw(input int fw, input int connect);
        return fw + clog2(connect);
    endfunction

    function automatic int calc_nbeat(input int dw, input int beat_w);
        return (dw + beat_w - 1) / beat_w;
    endfunction

    localparam int FW_DEFAULT             = 59;
    localparam int CONNECT_DEFAULT        = 2;
    localparam int CHIPDATA_WIDTH_DEFAULT = 16;

    localparam int DW    = calc_dw(FW_DEFAULT, CONNECT_DEFAULT);
    localparam int NBEAT = calc_nbeat(DW, CHIPDATA_WIDTH_DEFAULT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/chip_tx_fifo.sv
// Synchronous flit FIFO with registered full flag; a write while full is dropped,
// a read while empty is ignored, and read+write together keeps the count.
module chip_tx_fifo
    import pcss_chip_pkg::*;
#(
    parameter int WIDTH = 60,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int AW   = clog2(DEPTH);
    localparam int CNTW = clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             wr_ok, rd_ok;

    always_comb begin
        wr_ok    = wr_en && !full_q;
        rd_ok    = rd_en && (count_q != '0);
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CNTW'(wr_ok) - CNTW'(rd_ok);
        full_d   = (count_d == CNTW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/chip_link_tx.sv
// Off-chip link transmitter: buffers tagged flits, serializes them LSB beat first with
// per-beat parity, and replays a flit on far-end parity error. PCSS_CHIP_ODD_PARITY_EN selects odd parity.
module chip_link_tx
    import pcss_chip_pkg::*;
#(
    parameter int FW             = 59,
    parameter int CONNECT        = 2,
    parameter int CHIPDATA_WIDTH = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_RETRY      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          data_out_wr,
    input  logic [FW+clog2(CONNECT)-1:0]  data_out,
    output logic                          send_fifo_full,
    output logic [CHIPDATA_WIDTH-1:0]     send_data_out,
    output logic                          send_data_valid,
    output logic                          send_data_par,
    input  logic                          send_data_ready,
    input  logic                          send_data_err,
    output logic                          drop_pulse,
    output logic                          busy
);

    localparam int FLIT_W   = calc_dw(FW, CONNECT);
    localparam int NUM_BEAT = calc_nbeat(FLIT_W, CHIPDATA_WIDTH);
    localparam int PAD_W    = NUM_BEAT * CHIPDATA_WIDTH;
    localparam int BCW      = clog2(NUM_BEAT);
    localparam int RCW      = clog2(MAX_RETRY+1);
    localparam int FCW      = clog2(FIFO_DEPTH+1);

    logic              fifo_rd;
    logic              fifo_empty;
    logic [FLIT_W-1:0] fifo_head;
    logic [FCW-1:0]    fifo_count;

    chip_tx_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (data_out_wr),
        .wr_data (data_out),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (send_fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    tx_state_e         state_q, state_d;
    logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [RCW-1:0]    retry_cnt_q, retry_cnt_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              drop_q, drop_d;
    logic              handshake;
    logic              last_beat;
    logic              flit_end;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        retry_cnt_d = retry_cnt_q;
        flit_d      = flit_q;
        drop_d      = 1'b0;
        fifo_rd     = 1'b0;
        flit_end    = 1'b0;
        handshake   = (state_q == SEND) && send_data_ready;
        last_beat   = (beat_cnt_q == BCW'(NUM_BEAT-1));

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd     = 1'b1;
                    flit_d      = fifo_head;
                    beat_cnt_d  = '0;
                    retry_cnt_d = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (send_data_err) begin
                        if (retry_cnt_q < RCW'(MAX_RETRY)) begin
                            retry_cnt_d = retry_cnt_q + RCW'(1);
                            beat_cnt_d  = '0;
                        end else begin
                            drop_d   = 1'b1;
                            flit_end = 1'b1;
                        end
                    end else if (last_beat) begin
                        flit_end = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end

                    // Finished or dropped: chain straight into the next flit when one is waiting.
                    if (flit_end) begin
                        retry_cnt_d = '0;
                        beat_cnt_d  = '0;
                        if (!fifo_empty) begin
                            fifo_rd = 1'b1;
                            flit_d  = fifo_head;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            retry_cnt_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        flit_q <= flit_d;
    end

    logic [PAD_W-1:0] flit_pad;
    logic             beat_par;

    // Zero-extend so the unused top bits of the last beat go out as 0.
    always_comb begin
        flit_pad               = '0;
        flit_pad[FLIT_W-1:0]   = flit_q;
    end

    assign send_data_valid = (state_q == SEND);
    assign send_data_out   = send_data_valid ?
                             flit_pad[beat_cnt_q*CHIPDATA_WIDTH +: CHIPDATA_WIDTH] : '0;

`ifdef PCSS_CHIP_ODD_PARITY_EN
    assign beat_par = ~^send_data_out;
`else
    assign beat_par = ^send_data_out;
`endif

    assign send_data_par = send_data_valid & beat_par;
    assign drop_pulse    = drop_q;
    assign busy          = (fifo_count != '0) || (state_q == SEND);

endmodule

// File: tb/tb_chip_link_tx.sv
// Self-checking bench for chip_link_tx: beat table for a single flit plus scoreboarded sequences.
`timescale 1ns/1ps
module tb_chip_link_tx;
    import pcss_chip_pkg::*;

    localparam int BW   = 16;
    localparam int MAXR = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          data_out_wr = 1'b0;
    logic [DW-1:0] data_out = '0;
    logic          send_data_ready = 1'b0;
    logic          send_data_err = 1'b0;
    logic          send_fifo_full;
    logic [BW-1:0] send_data_out;
    logic          send_data_valid;
    logic          send_data_par;
    logic          drop_pulse;
    logic          busy;

    chip_link_tx #(
        .FW(59), .CONNECT(2), .CHIPDATA_WIDTH(BW), .FIFO_DEPTH(4), .MAX_RETRY(MAXR)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_out_wr     (data_out_wr),
        .data_out        (data_out),
        .send_fifo_full  (send_fifo_full),
        .send_data_out   (send_data_out),
        .send_data_valid (send_data_valid),
        .send_data_par   (send_data_par),
        .send_data_ready (send_data_ready),
        .send_data_err   (send_data_err),
        .drop_pulse      (drop_pulse),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_bad = 0;
    int            n_drop = 0;
    logic [DW-1:0] exp_q[$];
    int            m_bidx = 0;
    int            m_retry = 0;
    bit            exp_drop = 0;
    bit            prev_stall = 0;
    bit            expect_cont = 0;
    logic [BW-1:0] prev_data = '0;

    typedef struct {
        bit            rdy;
        bit            vld;
        logic [BW-1:0] data;
        bit            par;
        bit            bsy;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat_of(input logic [DW-1:0] f, input int k);
        logic [NBEAT*BW-1:0] p;
        p = '0;
        p[DW-1:0] = f;
        return p[k*BW +: BW];
    endfunction

    function automatic logic par_of(input logic [BW-1:0] b);
`ifdef PCSS_CHIP_ODD_PARITY_EN
        return ~^b;
`else
        return ^b;
`endif
    endfunction

    // One clock: check, drive at the falling edge, model the handshake of the coming rising edge.
    task automatic step(input bit rdy, input bit e, input bit wr, input logic [DW-1:0] d, input bit acc);
        logic [BW-1:0] eb;
        @(negedge clk);
        chk("drop_pulse", drop_pulse, exp_drop);
        if (drop_pulse) n_drop++;
        exp_drop = 0;
        if (prev_stall) begin
            chk("hold_valid", send_data_valid, 1);
            chk("hold_data", send_data_out, prev_data);
        end
        if (expect_cont) chk("no_bubble_valid", send_data_valid, 1);
        send_data_ready = rdy;
        send_data_err   = e;
        data_out_wr     = wr;
        data_out        = d;
        prev_stall  = send_data_valid && !rdy;
        prev_data   = send_data_out;
        expect_cont = 0;
        if (send_data_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", send_data_valid, 0);
            end else begin
                eb = beat_of(exp_q[0], m_bidx);
                chk($sformatf("beat%0d_data", m_bidx), send_data_out, eb);
                chk($sformatf("beat%0d_par", m_bidx), send_data_par, par_of(eb));
                if (e) begin
                    if (m_retry < MAXR) begin
                        m_retry++;
                        m_bidx = 0;
                    end else begin
                        exp_drop = 1;
                        void'(exp_q.pop_front());
                        m_retry = 0;
                        m_bidx  = 0;
                    end
                end else if (m_bidx == NBEAT-1) begin
                    void'(exp_q.pop_front());
                    m_retry = 0;
                    m_bidx  = 0;
                end else begin
                    m_bidx++;
                end
                expect_cont = (exp_q.size() != 0);
            end
        end
        if (wr && acc) exp_q.push_back(d);
    endtask

    // mode 0: clean; 1: err on beat 2 of first attempt of tgt; 2: err on every beat 0 of tgt
    task automatic drain(input int mode, input logic [DW-1:0] tgt);
        int n;
        bit e;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            e = 0;
            if (mode == 1) e = (m_bidx == 2 && m_retry == 0 && exp_q[0] == tgt);
            if (mode == 2) e = (m_bidx == 0 && exp_q[0] == tgt);
            step(1, e, 0, '0, 0);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        step(1, 0, 0, '0, 0);
        chk("idle_valid", send_data_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] f1, f2, f3, f4, f5, f6;
        logic [DW-1:0] ff[6];
        logic          ep;
        f1 = 60'hABCD123456789EF;
        f2 = 60'h123456789ABCDEF;
        f3 = 60'hFEDCBA987654321;
        f4 = 60'h5A5A5A5A5A5A5A5;
        f5 = 60'h0F0F0F0F0F0F0F0;
        f6 = 60'h13579BDF2468ACE;
        for (int i = 0; i < 6; i++) ff[i] = {$urandom(), $urandom()} & {DW{1'b1}};

        tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 16'h89EF, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 16'h4567, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 16'hD123, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 16'h0ABC, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", send_data_valid, 0);
        chk("rst_data", send_data_out, 0);
        chk("rst_par", send_data_par, 0);
        chk("rst_full", send_fifo_full, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Single flit, ready tied high, one beat per cycle
        step(1, 0, 1, f1, 1);
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].rdy, 0, 0, '0, 0);
`ifdef PCSS_CHIP_ODD_PARITY_EN
            ep = tbl[i].vld ? ~tbl[i].par : 1'b0;
`else
            ep = tbl[i].par;
`endif
            chk($sformatf("tbl%0d_valid", i), send_data_valid, tbl[i].vld);
            chk($sformatf("tbl%0d_data", i), send_data_out, tbl[i].data);
            chk($sformatf("tbl%0d_par", i), send_data_par, ep);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
        end

        // Backpressure: ready 1,0,0,1 starting at beat 0
        step(0, 0, 1, f2, 1);
        step(0, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        chk("bp_beat1_held", send_data_out, beat_of(f2, 1));
        step(1, 0, 0, '0, 0);
        drain(0, '0);

        // Error on beat 2 of the first attempt, replay succeeds
        n_drop = 0;
        step(1, 0, 1, f3, 1);
        drain(1, f3);
        chk("replay_drops", n_drop, 0);

        // Retry exhaustion: err on every beat 0, next flit follows
        n_drop = 0;
        step(1, 0, 1, f4, 1);
        step(1, 0, 1, f5, 1);
        drain(2, f4);
        chk("exhaust_drops", n_drop, 1);

        // FIFO full: one flit stalled in flight, then 5 writes, 5th ignored
        step(0, 0, 1, ff[0], 1);
        step(0, 0, 0, '0, 0);
        step(0, 0, 1, ff[1], 1);
        step(0, 0, 1, ff[2], 1);
        chk("full_after1", send_fifo_full, 0);
        step(0, 0, 1, ff[3], 1);
        chk("full_after2", send_fifo_full, 0);
        step(0, 0, 1, ff[4], 1);
        chk("full_after3", send_fifo_full, 0);
        step(0, 0, 1, ff[5], 0);
        chk("full_after4", send_fifo_full, 1);
        step(0, 0, 0, '0, 0);
        chk("full_after5", send_fifo_full, 1);
        chk("full_busy", busy, 1);
        drain(0, '0);
        chk("full_cleared", send_fifo_full, 0);

        // Reset during beat 2
        step(1, 0, 1, f6, 1);
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        @(negedge clk);
        chk("pre_rst_beat2", send_data_out, beat_of(f6, 2));
        rst_n = 1'b0;
        send_data_ready = 1'b0;
        #1;
        chk("mid_rst_valid", send_data_valid, 0);
        chk("mid_rst_data", send_data_out, 0);
        chk("mid_rst_par", send_data_par, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drop", drop_pulse, 0);
        exp_q.delete();
        m_bidx = 0;
        m_retry = 0;
        exp_drop = 0;
        prev_stall = 0;
        expect_cont = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, '0, 0);
            chk("post_rst_valid", send_data_valid, 0);
        end
        chk("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
